wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register index width (2^ADDR_W registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: writeback stage enable; 0 means stall.
REQ-006 The block SHALL have port MemtoReg, input, 1 bit: 1 selects ReadData, 0 selects ALUResult.
REQ-007 The block SHALL have port RegWrite, input, 1 bit: write request.
REQ-008 The block SHALL have port ReadData, input, DATA_W bits: memory load data from the MEM/WB stage.
REQ-009 The block SHALL have port ALUResult, input, DATA_W bits: ALU result from the MEM/WB stage.
REQ-010 The block SHALL have port WriteRegister, input, ADDR_W bits: destination register index.
REQ-011 The block SHALL have ports ReadRegister1 and ReadRegister2, input, ADDR_W bits each: source register indices.
REQ-012 The block SHALL have ports ReadData1 and ReadData2, output, DATA_W bits each: source operand values.
REQ-013 The block SHALL have port WriteData_Out, output, DATA_W bits: the selected writeback value, for forwarding.
REQ-014 The block SHALL have port RetireCount, output, 32 bits: count of committed register writes.

Function
REQ-015 WriteData_Out SHALL equal ReadData when MemtoReg=1 and ALUResult otherwise, combinationally, regardless of enable and RegWrite.
REQ-016 A write SHALL commit at the rising clk edge iff reset=0, enable=1, RegWrite=1 and WriteRegister!=0; register[WriteRegister] then takes WriteData_Out.
REQ-017 Register 0 SHALL read as 0 at all times; writes addressed to index 0 SHALL be discarded and SHALL NOT count.
REQ-018 Reads SHALL be combinational: ReadDataN equals register[ReadRegisterN] with zero-cycle latency.
REQ-019 Both read ports SHALL operate independently; identical indices on both ports SHALL return identical values.
REQ-020 RetireCount SHALL increment by 1 on every committed write and wrap from 0xFFFFFFFF to 0x00000000.
REQ-021 With enable=0, no register and no RetireCount change SHALL occur; reads and WriteData_Out remain live.

Reset
REQ-022 On a rising clk with reset=1, all registers and RetireCount SHALL become 0, overriding any simultaneous write.
REQ-023 While reset=1, the same-cycle bypass (REQ-025) SHALL be suppressed; read ports return stored contents.
REQ-024 After reset deasserts, the first write SHALL commit on the first rising edge meeting REQ-016.

Configuration
REQ-025 With WB_REGFILE_BYPASS_EN defined, a read whose index equals a committing write's nonzero WriteRegister in the same cycle SHALL return WriteData_Out (write-before-read).
REQ-026 Without WB_REGFILE_BYPASS_EN, such a read SHALL return the old stored value; the new value appears in the following cycle.

Structure
REQ-027 Constants DATA_W, ADDR_W and NUM_REGS SHALL reside in the shared pipeline package, together with the reset value of the register array.
REQ-028 The writeback select (REQ-015) SHALL be a sub-module named wb_select; the storage array, bypass and counter stay in wb_regfile.

Verification
REQ-029 Reset then read all 32 indices -> every ReadData1/ReadData2 = 0, RetireCount = 0.
REQ-030 enable=1, RegWrite=1, MemtoReg=0, ALUResult=0x12345678, WriteRegister=5; next cycle ReadRegister1=5 -> ReadData1 = 0x12345678, RetireCount = 1.
REQ-031 MemtoReg=1, ReadData=0xDEADBEEF, ALUResult=0x1, WriteRegister=0, RegWrite=1 -> WriteData_Out = 0xDEADBEEF; register 0 reads 0; RetireCount unchanged.
REQ-032 Write 0xA5A5A5A5 to register 7 with ReadRegister2=7 in the same cycle -> ReadData2 = 0xA5A5A5A5 with WB_REGFILE_BYPASS_EN; old value without it.
REQ-033 enable=0 with a valid write to register 3 -> register 3 unchanged, RetireCount unchanged; reset=1 with a write to register 9 -> register 9 = 0.
REQ-034 Force RetireCount to 0xFFFFFFFF via 2^32-1 commits (or a bench backdoor), then one commit -> RetireCount = 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the writeback register file.
package wb_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] REG_RESET = '0;
endpackage

// File: rtl/wb_regfile_select.sv
// Writeback value select: memory load data or ALU result.
module wb_select #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] data
);
  assign data = sel ? mem_data : alu_data;
endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file with two combinational read ports and a retire counter.
// Define WB_REGFILE_BYPASS_EN to forward a same-cycle committing write to the read ports.
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData_Out,
  output logic [31:0]       RetireCount
);
  import wb_regfile_pkg::*;

  localparam int REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [REGS];
  logic [31:0]       count_reg;
  logic              commit;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .sel      (MemtoReg),
    .mem_data (ReadData),
    .alu_data (ALUResult),
    .data     (WriteData_Out)
  );

  // Reset is folded in so the bypass below is also suppressed while in reset.
  assign commit = !reset && enable && RegWrite && (WriteRegister != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_reg[i] <= DATA_W'(REG_RESET);
      count_reg <= '0;
    end else if (commit) begin
      regs_reg[WriteRegister] <= WriteData_Out;
      count_reg               <= count_reg + 32'd1;
    end
  end

  assign rd_addr[0] = ReadRegister1;
  assign rd_addr[1] = ReadRegister2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = regs_reg[rd_addr[gi]];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rd_addr[gi] == WriteRegister)) rd_data[gi] = WriteData_Out;
`endif
        // Index 0 is hard-wired so it reads zero even before the first reset.
        if (rd_addr[gi] == '0) rd_data[gi] = '0;
      end
    end
  endgenerate

  assign ReadData1   = rd_data[0];
  assign ReadData2   = rd_data[1];
  assign RetireCount = count_reg;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default and bypass builds).
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset, enable, MemtoReg, RegWrite;
  logic [31:0] ReadData, ALUResult;
  logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2, WriteData_Out, RetireCount;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .ReadData      (ReadData),
    .ALUResult     (ALUResult),
    .WriteRegister (WriteRegister),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData_Out (WriteData_Out),
    .RetireCount   (RetireCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] old7;
    reset = 1'b1; enable = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    ReadData = '0; ALUResult = '0; WriteRegister = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_count", RetireCount, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check("reset_rd1", ReadData1, 32'h0);
      check("reset_rd2", ReadData2, 32'h0);
    end

    // ALU result into r5
    enable = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b0;
    ALUResult = 32'h1234_5678; WriteRegister = 5'd5;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd5;
    #1;
    check("wr5_rd1", ReadData1, 32'h1234_5678);
    check("wr5_count", RetireCount, 32'd1);

    // Load data selected, but destination is r0
    MemtoReg = 1'b1; ReadData = 32'hDEAD_BEEF; ALUResult = 32'h1;
    WriteRegister = 5'd0; RegWrite = 1'b1;
    #1;
    check("sel_mem", WriteData_Out, 32'hDEAD_BEEF);
    tick();
    ReadRegister1 = 5'd0; RegWrite = 1'b0;
    #1;
    check("r0_zero", ReadData1, 32'h0);
    check("r0_count", RetireCount, 32'd1);
    MemtoReg = 1'b0;
    #1;
    check("sel_alu", WriteData_Out, 32'h1);

    // Same-cycle read of a committing write to r7
    MemtoReg = 1'b0; ALUResult = 32'hA5A5_A5A5; WriteRegister = 5'd7;
    RegWrite = 1'b1; ReadRegister2 = 5'd7; ReadRegister1 = 5'd7;
`ifdef WB_REGFILE_BYPASS_EN
    old7 = 32'hA5A5_A5A5;
`else
    old7 = 32'h0;
`endif
    #1;
    check("same_cyc_rd2", ReadData2, old7);
    check("same_cyc_rd1", ReadData1, old7);
    tick();
    RegWrite = 1'b0;
    #1;
    check("r7_next_rd2", ReadData2, 32'hA5A5_A5A5);
    check("r7_count", RetireCount, 32'd2);

    // Stall: write to r3 must be held off
    ALUResult = 32'h1111_1111; WriteRegister = 5'd3; RegWrite = 1'b1;
    tick();
    check("r3_count", RetireCount, 32'd3);
    enable = 1'b0; ALUResult = 32'h2222_2222; ReadRegister1 = 5'd3;
    #1;
    check("stall_nobyp", ReadData1, 32'h1111_1111);
    check("stall_wdout", WriteData_Out, 32'h2222_2222);
    tick();
    check("stall_r3", ReadData1, 32'h1111_1111);
    check("stall_count", RetireCount, 32'd3);

    // r9 gets 0x55, then reset overrides a write of 0x99
    enable = 1'b1; ALUResult = 32'h0000_0055; WriteRegister = 5'd9;
    tick();
    reset = 1'b1; ALUResult = 32'h0000_0099; ReadRegister1 = 5'd9;
    #1;
    check("rst_nobyp", ReadData1, 32'h0000_0055);
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    #1;
    check("rst_r9", ReadData1, 32'h0);
    ReadRegister2 = 5'd5;
    #1;
    check("rst_r5", ReadData2, 32'h0);
    check("rst_count", RetireCount, 32'h0);

    // First write after reset commits immediately
    RegWrite = 1'b1; ALUResult = 32'hCAFE_F00D; WriteRegister = 5'd10;
    ReadRegister1 = 5'd10;
    tick();
    RegWrite = 1'b0;
    #1;
    check("post_rst_r10", ReadData1, 32'hCAFE_F00D);
    check("post_rst_cnt", RetireCount, 32'd1);

    // Counter wrap via backdoor preload
    dut.count_reg <= 32'hFFFF_FFFF;
    #1;
    check("preload_cnt", RetireCount, 32'hFFFF_FFFF);
    RegWrite = 1'b1; ALUResult = 32'h0BAD_C0DE; WriteRegister = 5'd11;
    ReadRegister2 = 5'd11;
    tick();
    RegWrite = 1'b0;
    #1;
    check("wrap_cnt", RetireCount, 32'h0);
    check("wrap_r11", ReadData2, 32'h0BAD_C0DE);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
